// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: shared opcodes, field layout and widths for fetch/decode and EX
package fetch_decode_pkg;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 16;
    localparam int PC_W    = 8;
    localparam int OP_W    = 6;
    localparam int REG_W   = 3;
    localparam logic [OP_W-1:0] OP_BZ     = 6'b100000;
    localparam logic [OP_W-1:0] OP_BC     = 6'b100001;
    localparam logic [OP_W-1:0] OP_JMP    = 6'b100010;
    localparam logic [OP_W-1:0] OP_NOP    = 6'b111111;
    localparam logic [OP_W-1:0] OP_EX_MAX = 6'd31;
    localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, 10'b0};
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             spare;
    } instr_t;
    function automatic logic is_ex_op(input logic [OP_W-1:0] op);
        return op <= OP_EX_MAX;
    endfunction
endpackage

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 8x16 register file, R0 hardwired to zero, write-first read bypass
module reg_file_8x16
    import fetch_decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr_a,
    input  logic [REG_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [8];

    // write port; R0 is never stored so it always reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // read ports with same-cycle write forwarding
    always_comb begin
        rdata_a = raddr_a == '0 ? '0 : (we && waddr == raddr_a) ? wdata : mem[raddr_a];
        rdata_b = raddr_b == '0 ? '0 : (we && waddr == raddr_b) ? wdata : mem[raddr_b];
    end
endmodule

// File: rtl/fetch_decode_block.sv
// fetch_decode_block: PC/IR fetch, branch resolution, operand decode and write-back tracking
module fetch_decode_block
    import fetch_decode_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               stall,
    input  logic [DATA_W-1:0]  ans_ex,
    input  logic [1:0]         flag_ex,
    output logic [PC_W-1:0]    pc_out,
    output logic [DATA_W-1:0]  A,
    output logic [DATA_W-1:0]  B,
    output logic [OP_W-1:0]    op_dec,
    output logic               valid_ex
);
    logic [PC_W-1:0]   pc;
    instr_t            ir;
    logic [REG_W-1:0]  rd_q;
    logic              wb_done;
    logic              taken;
    logic              we;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    assign pc_out = pc;

    // branch decision uses this cycle's flags; a write-back fires once per issued instruction
    always_comb begin
        taken = ir.op == OP_JMP || (ir.op == OP_BZ && flag_ex[0]) || (ir.op == OP_BC && flag_ex[1]);
        we    = valid_ex && !wb_done;
    end

    reg_file_8x16 u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (rd_q),
        .wdata   (ans_ex),
        .raddr_a (ir.rs),
        .raddr_b (ir.rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val)
    );

    // fetch, redirect/squash, issue; a stall freezes everything except marking the write-back done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            ir       <= NOP_WORD;
            A        <= '0;
            B        <= '0;
            op_dec   <= '0;
            valid_ex <= 1'b0;
            rd_q     <= '0;
            wb_done  <= 1'b0;
        end else if (stall) begin
            wb_done  <= wb_done || valid_ex;
        end else begin
            pc       <= taken ? ir[PC_W-1:0] : pc + 8'd1;
            ir       <= taken ? NOP_WORD : instr_in;
            valid_ex <= is_ex_op(ir.op);
            wb_done  <= 1'b0;
            if (is_ex_op(ir.op)) begin
                A      <= rs_val;
                B      <= rt_val;
                op_dec <= ir.op;
                rd_q   <= ir.rd;
            end
        end
    end
endmodule

// File: tb/tb_fetch_decode_block.sv
// tb_fetch_decode_block: directed scenarios for fetch/decode with a behavioural instruction memory
module tb_fetch_decode_block;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] ans_ex = '0;
    logic [1:0]  flag_ex = '0;
    logic [15:0] instr_in;
    logic [7:0]  pc_out;
    logic [15:0] A, B;
    logic [5:0]  op_dec;
    logic        valid_ex;
    logic [15:0] imem [256];
    int          passed = 0;
    int          total = 0;

    localparam logic [15:0] NOPW = 16'hFC00;

    fetch_decode_block dut (
        .clk      (clk),
        .reset    (reset),
        .instr_in (instr_in),
        .stall    (stall),
        .ans_ex   (ans_ex),
        .flag_ex  (flag_ex),
        .pc_out   (pc_out),
        .A        (A),
        .B        (B),
        .op_dec   (op_dec),
        .valid_ex (valid_ex)
    );

    assign instr_in = imem[pc_out];

    always #5 clk = ~clk;

    function automatic logic [15:0] alu(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 1'b0};
    endfunction

    function automatic logic [15:0] br(input logic [5:0] op, input logic [7:0] tgt);
        return {op, 2'b00, tgt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = NOPW;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        ans_ex = '0;
        flag_ex = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_pc(input string name, input logic [7:0] exp);
        total++;
        if (pc_out !== exp) $display("FAIL %s: pc_out=%h expected %h", name, pc_out, exp);
        else passed++;
    endtask

    task automatic chk_op(input string name, input logic [5:0] exp_op, input logic exp_v);
        total++;
        if (op_dec !== exp_op || valid_ex !== exp_v)
            $display("FAIL %s: op_dec=%0d valid_ex=%b expected op_dec=%0d valid_ex=%b", name, op_dec, valid_ex, exp_op, exp_v);
        else passed++;
    endtask

    task automatic chk_ab(input string name, input logic [15:0] ea, input logic [15:0] eb);
        total++;
        if (A !== ea || B !== eb) $display("FAIL %s: A=%h B=%h expected A=%h B=%h", name, A, B, ea, eb);
        else passed++;
    endtask

    task automatic test_reset();
        clear_mem();
        reset = 1'b1;
        step();
        chk_pc("reset_pc", 8'h00);
        chk_op("reset_op", 6'd0, 1'b0);
        chk_ab("reset_ab", 16'h0000, 16'h0000);
        reset = 1'b0;
    endtask

    task automatic test_alu_seq();
        clear_mem();
        imem[0] = alu(6'd0, 3'd1, 3'd0, 3'd0);
        imem[1] = alu(6'd1, 3'd2, 3'd0, 3'd0);
        imem[2] = alu(6'd2, 3'd3, 3'd0, 3'd0);
        do_reset();
        chk_pc("alu_pc0", 8'h00);
        step();
        chk_pc("alu_pc1", 8'h01);
        chk_op("alu_e1", 6'd0, 1'b0);
        step();
        chk_pc("alu_pc2", 8'h02);
        chk_op("alu_op0", 6'd0, 1'b1);
        step();
        chk_op("alu_op1", 6'd1, 1'b1);
        step();
        chk_op("alu_op2", 6'd2, 1'b1);
    endtask

    task automatic test_jump();
        clear_mem();
        imem[4] = alu(6'd6, 3'd0, 3'd0, 3'd0);
        imem[5] = br(6'b100010, 8'h40);
        imem[6] = alu(6'd5, 3'd0, 3'd0, 3'd0);
        imem[8'h40] = alu(6'd7, 3'd0, 3'd0, 3'd0);
        imem[8'h41] = alu(6'd8, 3'd0, 3'd0, 3'd0);
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk_pc("jmp_at05", 8'h05);
        step();
        chk_op("jmp_prev_issue", 6'd6, 1'b1);
        step();
        chk_pc("jmp_target", 8'h40);
        chk_op("jmp_branch_slot", 6'd6, 1'b0);
        step();
        chk_pc("jmp_seq", 8'h41);
        chk_op("jmp_bubble", 6'd6, 1'b0);
        step();
        chk_op("jmp_target_issue", 6'd7, 1'b1);
        step();
        chk_op("jmp_next_issue", 6'd8, 1'b1);
    endtask

    task automatic test_bz();
        clear_mem();
        imem[0] = br(6'b100000, 8'h20);
        imem[1] = alu(6'd3, 3'd0, 3'd0, 3'd0);
        imem[8'h20] = alu(6'd4, 3'd0, 3'd0, 3'd0);
        do_reset();
        flag_ex = 2'b01;
        step();
        step();
        chk_pc("bz_taken_pc", 8'h20);
        chk_op("bz_taken_slot", 6'd0, 1'b0);
        flag_ex = 2'b00;
        step();
        step();
        chk_op("bz_taken_issue", 6'd4, 1'b1);
        do_reset();
        flag_ex = 2'b00;
        step();
        flag_ex = 2'b10;
        step();
        chk_pc("bz_untaken_pc", 8'h02);
        chk_op("bz_untaken_slot", 6'd0, 1'b0);
        step();
        chk_op("bz_untaken_issue", 6'd3, 1'b1);
        chk_pc("bz_untaken_pc3", 8'h03);
    endtask

    task automatic test_back_to_back();
        clear_mem();
        imem[0] = alu(6'd1, 3'd3, 3'd0, 3'd0);
        imem[1] = alu(6'd2, 3'd0, 3'd3, 3'd3);
        imem[2] = alu(6'd3, 3'd0, 3'd0, 3'd3);
        imem[3] = alu(6'd4, 3'd0, 3'd0, 3'd3);
        do_reset();
        step();
        step();
        ans_ex = 16'h1234;
        step();
        chk_ab("bypass_r3", 16'h1234, 16'h1234);
        ans_ex = 16'hFFFF;
        step();
        chk_ab("r0_same_cycle", 16'h0000, 16'h1234);
        ans_ex = 16'h0000;
        step();
        chk_ab("r0_after_write", 16'h0000, 16'h1234);
    endtask

    task automatic test_stall();
        clear_mem();
        imem[0] = alu(6'd1, 3'd0, 3'd0, 3'd0);
        imem[1] = alu(6'd2, 3'd5, 3'd0, 3'd0);
        imem[2] = alu(6'd3, 3'd0, 3'd5, 3'd0);
        imem[3] = alu(6'd4, 3'd0, 3'd0, 3'd0);
        do_reset();
        for (int i = 0; i < 3; i++) step();
        chk_pc("stall_pre_pc", 8'h03);
        stall = 1'b1;
        ans_ex = 16'h0055;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pc("stall_pc", 8'h03);
            chk_op("stall_op", 6'd2, 1'b1);
            chk_ab("stall_ab", 16'h0000, 16'h0000);
        end
        ans_ex = 16'hBEEF;
        stall = 1'b0;
        step();
        chk_pc("resume_pc", 8'h04);
        chk_op("resume_op", 6'd3, 1'b1);
        chk_ab("resume_wb_once", 16'h0055, 16'h0000);
        ans_ex = 16'h0000;
        step();
        chk_op("resume_next", 6'd4, 1'b1);
        chk_pc("resume_pc5", 8'h05);
    endtask

    task automatic test_wrap_reset();
        clear_mem();
        imem[0] = br(6'b100010, 8'hFD);
        imem[8'hFE] = alu(6'd9, 3'd0, 3'd0, 3'd0);
        do_reset();
        step();
        step();
        chk_pc("wrap_jmp_fd", 8'hFD);
        step();
        step();
        chk_pc("wrap_at_ff", 8'hFF);
        step();
        chk_pc("wrap_to_00", 8'h00);
        chk_op("wrap_issue", 6'd9, 1'b1);
        step();
        chk_pc("wrap_pc01", 8'h01);
        chk_op("wrap_hold", 6'd9, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_pc("async_rst_pc", 8'h00);
        chk_op("async_rst_op", 6'd0, 1'b0);
        chk_ab("async_rst_ab", 16'h0000, 16'h0000);
        step();
        chk_pc("rst_held_pc", 8'h00);
        reset = 1'b0;
        chk_pc("restart_pc", 8'h00);
        step();
        chk_pc("restart_pc1", 8'h01);
        step();
        chk_pc("restart_jmp", 8'hFD);
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_jump();
        test_bz();
        test_back_to_back();
        test_stall();
        test_wrap_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
